exhaustive_stim_seq: RTL and testbench
======================================

# exhaustive_stim_seq

Synthesizable exhaustive stimulus sequencer that sits directly upstream of a combinational DUT such as `and_gate`. It walks the full 2^IN_W input space in binary order and holds each vector for a programmable settle time. It then samples the DUT response and hands {vector, response} downstream over a valid/ready handshake. Optionally, it compacts all accepted responses into a 32-bit signature.

## Interface
Parameters:
- `IN_W`, 5, width of the DUT input vector; 1..16.
- `OUT_W`, 6, width of the DUT response bus; 1..32.
- `SETTLE`, 1, cycles each vector is held before the response is sampled; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a sweep; sampled only in IDLE or DONE.
- `stim` out IN_W: vector driven onto the DUT inputs.
- `dut_resp` in OUT_W: DUT outputs.
- `resp_valid` out 1: captured response available.
- `resp_ready` in 1: downstream accepts the response.
- `resp_vec` out IN_W: vector that produced `resp_data`.
- `resp_data` out OUT_W: captured DUT response.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete; held until the next `start` or reset.
- `signature` out 32: MISR result (see Configuration).

## Operation
- Reset values: state IDLE; `stim`, `resp_vec`, `resp_data` = 0; `resp_valid`, `busy`, `done` = 0; settle counter 0; `signature` = 32'hFFFF_FFFF with the macro, 0 without.
- States:
  - IDLE / DONE: if `start`=1, go to APPLY with `stim`=0, settle count 0, `done`=0, `busy`=1, signature re-seeded.
  - APPLY: hold `stim` for SETTLE cycles. On the last cycle's edge:
    - `resp_data` <= `dut_resp`
    - `resp_vec` <= `stim`
    - `resp_valid` <= 1
    - go to PRESENT
  - PRESENT: hold `resp_valid`, `resp_data` and `resp_vec` stable until `resp_ready`=1. On the transfer edge, `resp_valid` <= 0. Then:
    - if `stim` = all-ones: go to DONE, `busy` <= 0, `done` <= 1.
    - else: `stim` <= `stim`+1 and go to APPLY.
- `stim` never wraps during a sweep. The all-ones vector is the final one; no 2^IN_W+1th vector is issued.
- `start` asserted while `busy` is ignored.
- `resp_ready` asserted while `resp_valid`=0 has no effect.
- `rst_n` low mid-sweep returns the block to the reset values immediately, regardless of the clock. Any pending response is dropped.
- `stim` changes only on the edge leaving PRESENT, or on the edge leaving IDLE/DONE.

## Timing
- Count the `start`-sampling edge as edge 0.
- With `resp_ready` tied high, each vector occupies SETTLE+1 cycles.
- `done` rises on edge 2^IN_W·(SETTLE+1). For IN_W=5 and SETTLE=1, that is edge 64.
- Response latency: `resp_valid` rises SETTLE edges after `stim` changes.
- Backpressure stretches PRESENT only. The settle time is never shortened.
- `busy` and `done` are never both 1.

## Configuration
- `EXHAUSTIVE_STIM_SIGNATURE_EN` defined: a 32-bit MISR updates on every accepted transfer (`resp_valid`&&`resp_ready`).
  - Update: sig <= {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 0) ^ zero-extended `resp_data`.
  - Seeded to 32'hFFFF_FFFF on reset and on `start`.
  - Stable while `done`=1.
- Undefined: no MISR logic is built, and `signature` is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `tb_gen_pkg` holds:
  - the state enum (IDLE, APPLY, PRESENT, DONE);
  - `MISR_POLY` = 32'h04C1_1DB7;
  - `MISR_SEED` = 32'hFFFF_FFFF.
- One sub-module, `tb_gen_misr` (OUT_W-parameterised, enable + seed-load inputs), is instantiated only under the macro.
- The FSM, settle counter and vector counter live in the top module.

## Test plan
- Reset mid-sweep: assert `rst_n`=0 at vector 7 while `resp_valid`=1. Required: all outputs go to reset values asynchronously, and a fresh `start` restarts from `stim`=0.
- Full sweep, no backpressure: IN_W=5, SETTLE=1, `resp_ready`=1, DUT = and_gate model. Required:
  - 32 transfers with `resp_vec` = 0..31 in order;
  - `resp_data` matches the model;
  - `done` rises at edge 64, `busy` falls on the same edge.
- Backpressure: hold `resp_ready`=0 for 5 cycles on vector 3. Required: `resp_valid`, `resp_vec`=3 and `resp_data` stay constant; `stim` stays 3; vector 4 is applied on the edge after the transfer.
- Long settle: SETTLE=4, DUT output registered with 3-cycle delay. Required: every captured `resp_data` equals the delayed model value, with zero mismatches over 32 vectors.
- Start handling: pulse `start` at vector 10, then again in DONE. Required: the first pulse is ignored (sweep continues); the second clears `done` and restarts at `stim`=0.
- Signature (macro defined): full sweep against the and_gate model. Required: `signature` equals the bench's MISR reference value; with the macro undefined, `signature`=0 throughout.

Source files
------------

// File: rtl/tb_gen_pkg.sv
// Shared definitions for the exhaustive stimulus sequencer.
//   - state_e   : sequencer FSM states
//   - MISR_POLY : feedback polynomial of the response signature register
//   - MISR_SEED : value loaded into the signature on reset and on start
//   - misr_next : one signature compaction step
package tb_gen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

    // Shift left, fold the bit that fell out back in through the polynomial,
    // then mix in the new response word.
    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [31:0] data);
        logic [31:0] fb;
        fb = sig[31] ? MISR_POLY : 32'h0;
        return {sig[30:0], 1'b0} ^ fb ^ data;
    endfunction

endpackage

// File: rtl/tb_gen_misr.sv
// 32-bit multiple-input signature register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (loads MISR_SEED)
//   en          : compact `data` into the signature this cycle
//   seed_load   : reload MISR_SEED (wins over en)
//   data        : response word, zero-extended to 32 bits
//   sig         : current signature
module tb_gen_misr
    import tb_gen_pkg::*;
#(
    parameter int OUT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [OUT_W-1:0] data,
    output logic [31:0]      sig
);

    logic [31:0] sig_q;
    logic [31:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (seed_load) begin
            sig_d = MISR_SEED;
        end else if (en) begin
            sig_d = misr_next(sig_q, 32'(data));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/exhaustive_stim_seq.sv
// Exhaustive stimulus sequencer: walks every IN_W-bit vector in binary order,
// holds each for SETTLE cycles, samples the downstream combinational DUT and
// offers {vector, response} on a valid/ready port.
// Optional feature macro: EXHAUSTIVE_STIM_SIGNATURE_EN builds a 32-bit MISR
// over accepted responses; without it `signature` is tied to 0.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begin a sweep (honoured in IDLE or DONE only)
//   stim                 : vector driven onto the DUT
//   dut_resp             : DUT response
//   resp_valid/resp_ready: response handshake
//   resp_vec, resp_data  : vector and captured response
//   busy, done           : sweep in progress / sweep finished
//   signature            : MISR result (0 when the feature is not built)
//
// Handshake: resp_valid, resp_vec and resp_data are held stable from the
// capture edge until an edge where resp_valid && resp_ready; that edge is the
// transfer. resp_ready while resp_valid is low is ignored.
module exhaustive_stim_seq
    import tb_gen_pkg::*;
#(
    parameter int IN_W   = 5,
    parameter int OUT_W  = 6,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] dut_resp,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IN_W-1:0]  resp_vec,
    output logic [OUT_W-1:0] resp_data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      signature
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [IN_W-1:0]  stim_q, stim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  resp_vec_q, resp_vec_d;
    logic [OUT_W-1:0] resp_data_q, resp_data_d;
    logic             resp_valid_q, resp_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_ok;

    assign start_ok = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        cnt_d        = cnt_q;
        resp_vec_d   = resp_vec_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        done_d       = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = APPLY;
                    stim_d  = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            APPLY: begin
                // The counter marks the last settle cycle; the DUT output is
                // sampled on that cycle's closing edge.
                if (cnt_q == CNT_LAST) begin
                    resp_data_d  = dut_resp;
                    resp_vec_d   = stim_q;
                    resp_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = PRESENT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESENT: begin
                // resp_valid is always high here, so ready alone is a transfer.
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    if (&stim_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stim_d  = stim_q + 1'b1;
                        state_d = APPLY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            stim_q       <= '0;
            cnt_q        <= '0;
            resp_vec_q   <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stim_q       <= stim_d;
            cnt_q        <= cnt_d;
            resp_vec_q   <= resp_vec_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign stim       = stim_q;
    assign resp_vec   = resp_vec_q;
    assign resp_data  = resp_data_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef EXHAUSTIVE_STIM_SIGNATURE_EN
    tb_gen_misr #(
        .OUT_W(OUT_W)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (resp_valid_q && resp_ready),
        .seed_load(start_ok),
        .data     (resp_data_q),
        .sig      (signature)
    );
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign signature = 32'h0;
`endif

endmodule

// File: tb/tb_exhaustive_stim_seq.sv
// Bench for exhaustive_stim_seq. Instance A (SETTLE=1) faces a combinational
// AND-gate network; instance B (SETTLE=4) faces the same network behind a
// three-register delay.
module tb_exhaustive_stim_seq;

    localparam int IN_W  = 5;
    localparam int OUT_W = 6;
    localparam int NV    = 32;
    localparam int EW    = IN_W + OUT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT model: six 2-input/5-input AND gates ----------------
    function automatic logic [OUT_W-1:0] and_model(input logic [IN_W-1:0] v);
        logic [OUT_W-1:0] r;
        r[0] = (v == 5'h1f);
        for (int i = 1; i < OUT_W; i++) r[i] = v[i-1] & v[i % IN_W];
        return r;
    endfunction

    function automatic logic [31:0] sig_ref();
        logic [31:0] s;
        s = 32'hFFFF_FFFF;
        for (int v = 0; v < NV; v++) begin
            s = (s << 1) ^ (s[31] ? 32'h04C1_1DB7 : 32'h0)
                ^ {26'h0, and_model(IN_W'(v))};
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instance A ----------------
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             resp_ready = 1'b0;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] dut_resp;
    logic             resp_valid;
    logic [IN_W-1:0]  resp_vec;
    logic [OUT_W-1:0] resp_data;
    logic             busy;
    logic             done;
    logic [31:0]      signature;

    assign dut_resp = and_model(stim);

    exhaustive_stim_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim),
        .dut_resp(dut_resp), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_vec(resp_vec), .resp_data(resp_data), .busy(busy), .done(done),
        .signature(signature)
    );

    // ---------------- instance B ----------------
    logic             b_rst_n = 1'b0;
    logic             b_start = 1'b0;
    logic             b_ready = 1'b0;
    logic [IN_W-1:0]  b_stim;
    logic [OUT_W-1:0] b_dut_resp;
    logic             b_valid;
    logic [IN_W-1:0]  b_vec;
    logic [OUT_W-1:0] b_data;
    logic             b_busy;
    logic             b_done;
    logic [31:0]      b_sig;
    logic [OUT_W-1:0] d1, d2, d3;

    always @(posedge clk) begin
        d1 <= and_model(b_stim);
        d2 <= d1;
        d3 <= d2;
    end
    assign b_dut_resp = d3;

    exhaustive_stim_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(4)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .stim(b_stim),
        .dut_resp(b_dut_resp), .resp_valid(b_valid), .resp_ready(b_ready),
        .resp_vec(b_vec), .resp_data(b_data), .busy(b_busy), .done(b_done),
        .signature(b_sig)
    );

    // ---------------- scoreboards ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_b_q[$];

    task automatic push_sweep(input bit to_b);
        for (int v = 0; v < NV; v++) begin
            if (to_b) exp_b_q.push_back({IN_W'(v), and_model(IN_W'(v))});
            else      exp_q.push_back({IN_W'(v), and_model(IN_W'(v))});
        end
    endtask

    always @(negedge clk) begin : mon_a
        logic [EW-1:0] e;
        if (rst_n) begin
            check("busy_done_excl", 32'(busy && done), 0);
`ifndef EXHAUSTIVE_STIM_SIGNATURE_EN
            check("sig_zero", signature, 0);
`endif
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_xfer: got vec %0d expected none", resp_vec);
                end else begin
                    e = exp_q.pop_front();
                    check("a_xfer_vec", 32'(resp_vec), 32'(e[EW-1:OUT_W]));
                    check("a_xfer_data", 32'(resp_data), 32'(e[OUT_W-1:0]));
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [EW-1:0] e;
        if (b_rst_n && b_valid && b_ready) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_xfer: got vec %0d expected none", b_vec);
            end else begin
                e = exp_b_q.pop_front();
                check("b_xfer_vec", 32'(b_vec), 32'(e[EW-1:OUT_W]));
                check("b_xfer_data", 32'(b_data), 32'(e[OUT_W-1:0]));
            end
        end
    end

    function automatic logic [31:0] exp_sig_done();
`ifdef EXHAUSTIVE_STIM_SIGNATURE_EN
        return sig_ref();
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] exp_sig_reset();
`ifdef EXHAUSTIVE_STIM_SIGNATURE_EN
        return 32'hFFFF_FFFF;
`else
        return 32'h0;
`endif
    endfunction

    task automatic check_reset_a(input string tag);
        check({tag, "_stim"}, 32'(stim), 0);
        check({tag, "_vec"}, 32'(resp_vec), 0);
        check({tag, "_data"}, 32'(resp_data), 0);
        check({tag, "_valid"}, 32'(resp_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_sig"}, signature, exp_sig_reset());
    endtask

    // mode 0: ready high; 1: random ready; 2: 5-cycle stall on vector 3;
    // 3: ready high plus a start pulse at vector 10
    task automatic run_sweep(input int mode);
        int edges;
        int hold;
        logic was_busy;
        logic pulsed;
        logic pulse;
        logic xfer3;
        logic [OUT_W-1:0] snap;
        edges = 0;
        hold = 0;
        pulsed = 1'b0;
        was_busy = 1'b0;
        snap = '0;
        push_sweep(1'b0);
        resp_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_stim", 32'(stim), 0);
        check("start_busy", 32'(busy), 1);
        check("start_done", 32'(done), 0);
        check("start_valid", 32'(resp_valid), 0);
        while (!done && edges < 4000) begin
            pulse = 1'b0;
            case (mode)
                1: resp_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (resp_valid && resp_vec == 3 && hold < 5) begin
                        if (hold == 0) begin
                            snap = resp_data;
                        end else begin
                            check("bp_valid", 32'(resp_valid), 1);
                            check("bp_vec", 32'(resp_vec), 3);
                            check("bp_data", 32'(resp_data), 32'(snap));
                            check("bp_stim", 32'(stim), 3);
                        end
                        hold++;
                        resp_ready = 1'b0;
                    end else begin
                        resp_ready = 1'b1;
                    end
                end
                default: resp_ready = 1'b1;
            endcase
            if (mode == 3 && !pulsed && stim == 10 && !resp_valid) begin
                start = 1'b1;
                pulsed = 1'b1;
                pulse = 1'b1;
            end
            xfer3 = (mode == 2) && resp_valid && resp_ready && resp_vec == 3;
            was_busy = busy;
            @(posedge clk);
            edges++;
            #1;
            start = 1'b0;
            if (xfer3) begin
                check("bp_next_stim", 32'(stim), 4);
                check("bp_valid_drop", 32'(resp_valid), 0);
            end
            if (pulse) begin
                check("ign_start_busy", 32'(busy), 1);
                check("ign_start_stim", 32'(stim), 10);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: got %0d edges without done, required done", edges);
        end
        if (mode == 0) begin
            check("done_edge", 32'(edges), 64);
            check("busy_before_done", 32'(was_busy), 1);
        end
        if (mode == 2) check("bp_hold_cycles", 32'(hold), 5);
        if (mode == 3) check("ign_start_pulsed", 32'(pulsed), 1);
        check("end_busy", 32'(busy), 0);
        check("end_done", 32'(done), 1);
        check("end_stim", 32'(stim), 31);
        check("end_sig", signature, exp_sig_done());
        resp_ready = 1'($urandom_range(0, 1));
        repeat (3) @(posedge clk);
        #1;
        check("idle_done_held", 32'(done), 1);
        check("idle_sig_stable", signature, exp_sig_done());
        check("queue_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic reset_mid_sweep();
        int n;
        n = 0;
        push_sweep(1'b0);
        resp_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!(resp_valid && resp_vec == 7) && n < 1000) begin
            @(posedge clk);
            n++;
            #1;
        end
        resp_ready = 1'b0;
        check("rst_reached_vec7", 32'(resp_valid && resp_vec == 7), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_a("rst_async");
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset_a("rst_held");
        rst_n = 1'b1;
    endtask

    task automatic run_b();
        int edges;
        edges = 0;
        push_sweep(1'b1);
        b_ready = 1'b1;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        check("b_start_stim", 32'(b_stim), 0);
        while (!b_done && edges < 4000) begin
            @(posedge clk);
            edges++;
            #1;
        end
        check("b_done_edge", 32'(edges), 160);
        check("b_end_busy", 32'(b_busy), 0);
        check("b_queue_empty", 32'(exp_b_q.size()), 0);
        check("b_end_sig", b_sig, exp_sig_done());
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        repeat (2) @(posedge clk);
        #1;
        check_reset_a("reset");
        check("b_reset_stim", 32'(b_stim), 0);
        check("b_reset_valid", 32'(b_valid), 0);
        rst_n = 1'b1;
        b_rst_n = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_start_busy", 32'(busy), 0);
        run_sweep(0);
        run_sweep(3);
        run_sweep(1);
        run_sweep(2);
        reset_mid_sweep();
        run_sweep(0);
        run_b();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
